// File: rtl/ssd_round_ctrl_if.sv
// ssd_round_ctrl_if: control, score and display signals of the round timer
interface ssd_round_ctrl_if;
    logic       start;
    logic       pause;
    logic [6:0] score;
    logic       score_valid;
    logic [3:0] digit_one;
    logic [3:0] digit_two;
    logic       one_en;
    logic       two_en;
    logic       time_up;
    logic [1:0] state;
    modport master (
        output start, pause, score, score_valid,
        input  digit_one, digit_two, one_en, two_en, time_up, state
    );
    modport slave (
        input  start, pause, score, score_valid,
        output digit_one, digit_two, one_en, two_en, time_up, state
    );
endinterface

// File: rtl/ssd_round_ctrl.sv
// ssd_round_ctrl: two-digit countdown round timer with score display; SSD_ROUND_BLINK_EN adds final-seconds blink
module ssd_round_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int ROUND_SEC = 60,
    parameter int BLINK_SEC = 5
) (
    input  logic fast_clk,
    input  logic rst_n,
    ssd_round_ctrl_if.slave io
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0] R_T = 4'(ROUND_SEC / 10);
    localparam logic [3:0] R_O = 4'(ROUND_SEC % 10);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_e;
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [3:0]    sct_q, sct_d, sco_q, sco_d;
    logic [3:0]    dig1_q, dig1_d, dig2_q, dig2_d;
    logic          en1_q, en1_d, en2_q, en2_d, tu_q, tu_d;
    logic          tick, last, blank;
    logic [6:0]    sat;
`ifdef SSD_ROUND_BLINK_EN
    int            secs_v;
`endif
    // Next-state: start overrides everything; the prescaler advances on every RUN cycle, including the one that pauses
    always_comb begin
        tick    = state_q == RUN && presc_q == P_MAX;
        last    = tens_q == 4'd0 && ones_q == 4'd1;
        sat     = io.score > 7'd99 ? 7'd99 : io.score;
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        sct_d   = sct_q;
        sco_d   = sco_q;
        tu_d    = 1'b0;
        if (io.start) begin
            state_d = RUN;
            presc_d = '0;
            tens_d  = R_T;
            ones_d  = R_O;
            sct_d   = '0;
            sco_d   = '0;
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                ones_d = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
                tens_d = ones_q == 4'd0 ? tens_q - 4'd1 : tens_q;
                tu_d   = last;
            end
            state_d = tick && last ? DONE : io.pause ? PAUSE : RUN;
        end else if (state_q == PAUSE && io.pause) begin
            state_d = RUN;
        end else if (state_q == DONE && io.score_valid) begin
            sct_d = 4'(sat / 7'd10);
            sco_d = 4'(sat % 7'd10);
        end
`ifdef SSD_ROUND_BLINK_EN
        secs_v = int'(tens_d) * 10 + int'(ones_d);
        blank  = state_d == RUN && secs_v >= 1 && secs_v <= BLINK_SEC && int'(presc_d) >= CLK_HZ / 2;
`else
        blank  = 1'b0;
`endif
        dig1_d = state_d == DONE ? sct_d : tens_d;
        dig2_d = state_d == DONE ? sco_d : ones_d;
        en1_d  = (state_d == DONE || tens_d != 4'd0) && !blank;
        en2_d  = !blank;
    end
    // State, counters and registered display outputs
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            tens_q  <= R_T;
            ones_q  <= R_O;
            sct_q   <= '0;
            sco_q   <= '0;
            tu_q    <= 1'b0;
            dig1_q  <= R_T;
            dig2_q  <= R_O;
            en1_q   <= R_T != 4'd0;
            en2_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            sct_q   <= sct_d;
            sco_q   <= sco_d;
            tu_q    <= tu_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
        end
    end
    assign io.digit_one = dig1_q;
    assign io.digit_two = dig2_q;
    assign io.one_en    = en1_q;
    assign io.two_en    = en2_q;
    assign io.time_up   = tu_q;
    assign io.state     = state_q;
endmodule

// File: tb/tb_ssd_round_ctrl.sv
// tb_ssd_round_ctrl: directed checks of the round timer at CLK_HZ=10, ROUND_SEC=12, BLINK_SEC=5
module tb_ssd_round_ctrl;
`ifdef SSD_ROUND_BLINK_EN
    localparam int BLINK = 1;
`else
    localparam int BLINK = 0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   n_run = 0;
    int   n_fail = 0;
    int   tu_cnt = 0;
    ssd_round_ctrl_if io ();
    ssd_round_ctrl #(.CLK_HZ(10), .ROUND_SEC(12), .BLINK_SEC(5)) dut (
        .fast_clk(clk),
        .rst_n(rst_n),
        .io(io)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (io.time_up === 1'b1) tu_cnt++;
    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pstart();
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
    endtask
    task automatic ppause();
        io.pause = 1'b1;
        @(negedge clk);
        io.pause = 1'b0;
    endtask
    task automatic pscore(input int v);
        io.score = 7'(v);
        io.score_valid = 1'b1;
        @(negedge clk);
        io.score_valid = 1'b0;
    endtask
    task automatic digits(input string tag, input int d1, input int d2);
        check({tag, "_d1"}, int'(io.digit_one), d1);
        check({tag, "_d2"}, int'(io.digit_two), d2);
    endtask
    initial begin
        io.start = 1'b0;
        io.pause = 1'b0;
        io.score = '0;
        io.score_valid = 1'b0;
        rst_n = 1'b0;
        cycles(3);
        digits("rst", 1, 2);
        check("rst_en1", int'(io.one_en), 1);
        check("rst_en2", int'(io.two_en), 1);
        check("rst_state", int'(io.state), 0);
        check("rst_tu", int'(io.time_up), 0);
        rst_n = 1'b1;
        cycles(2);
        check("idle_state", int'(io.state), 0);
        pstart();
        check("run_state", int'(io.state), 1);
        digits("run0", 1, 2);
        cycles(9);
        digits("run9", 1, 2);
        cycles(1);
        digits("run10", 1, 1);
        cycles(20);
        digits("sec09", 0, 9);
        check("sec09_en1", int'(io.one_en), 0);
        check("sec09_en2", int'(io.two_en), 1);
        cycles(60);
        digits("sec03", 0, 3);
        check("sec03_p0_en2", int'(io.two_en), 1);
        cycles(4);
        check("sec03_p4_en2", int'(io.two_en), 1);
        cycles(1);
        check("sec03_p5_en2", int'(io.two_en), BLINK ? 0 : 1);
        check("sec03_p5_en1", int'(io.one_en), 0);
        cycles(4);
        check("sec03_p9_en2", int'(io.two_en), BLINK ? 0 : 1);
        cycles(1);
        digits("sec02", 0, 2);
        check("sec02_p0_en2", int'(io.two_en), 1);
        cycles(19);
        check("pre_exp_state", int'(io.state), 1);
        check("pre_exp_tu", int'(io.time_up), 0);
        digits("sec01", 0, 1);
        cycles(1);
        check("exp_state", int'(io.state), 3);
        check("exp_tu", int'(io.time_up), 1);
        digits("exp", 0, 0);
        check("exp_en1", int'(io.one_en), 1);
        check("exp_en2", int'(io.two_en), 1);
        cycles(1);
        check("exp_tu_off", int'(io.time_up), 0);
        ppause();
        check("done_pause_state", int'(io.state), 3);
        digits("done_pause", 0, 0);
        pscore(123);
        digits("score123", 9, 9);
        pscore(47);
        digits("score47", 4, 7);
        check("score47_en1", int'(io.one_en), 1);
        pstart();
        check("restart_state", int'(io.state), 1);
        digits("restart", 1, 2);
        cycles(50);
        digits("p_sec07", 0, 7);
        ppause();
        check("paused_state", int'(io.state), 2);
        cycles(49);
        check("paused_hold_state", int'(io.state), 2);
        digits("paused_hold", 0, 7);
        check("paused_en2", int'(io.two_en), 1);
        ppause();
        check("resume_state", int'(io.state), 1);
        cycles(68);
        check("p_pre_exp_state", int'(io.state), 1);
        check("p_pre_exp_tu", int'(io.time_up), 0);
        digits("p_sec01", 0, 1);
        cycles(1);
        check("p_exp_state", int'(io.state), 3);
        check("p_exp_tu", int'(io.time_up), 1);
        pstart();
        cycles(25);
        digits("sp_sec10", 1, 0);
        io.start = 1'b1;
        io.pause = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        io.pause = 1'b0;
        check("sp_state", int'(io.state), 1);
        digits("sp", 1, 2);
        cycles(10);
        check("sp_run_state", int'(io.state), 1);
        digits("sp_run", 1, 1);
        cycles(5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(io.state), 0);
        digits("mid_rst", 1, 2);
        check("mid_rst_tu", int'(io.time_up), 0);
        @(negedge clk);
        cycles(2);
        rst_n = 1'b1;
        cycles(130);
        check("post_rst_state", int'(io.state), 0);
        digits("post_rst", 1, 2);
        check("tu_pulses", tu_cnt, 2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ssd_round_ctrl.md
SSD_ROUND_CTRL -- requirements
Module: ssd_round_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, fast_clk cycles per second.
REQ-002 Parameter ROUND_SEC, default 60, round length in seconds; legal range 1..99.
REQ-003 Parameter BLINK_SEC, default 5, final-seconds window in which the display blinks.
REQ-004 fast_clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse; begin or restart a round.
REQ-007 pause  in  1  one-cycle pulse; toggle RUN/PAUSE.
REQ-008 score  in  7  binary words-per-minute result.
REQ-009 score_valid  in  1  one-cycle pulse qualifying score.
REQ-010 digit_one  out  4  BCD tens digit to display driver.
REQ-011 digit_two  out  4  BCD ones digit to display driver.
REQ-012 one_en  out  1  tens digit enable.
REQ-013 two_en  out  1  ones digit enable.
REQ-014 time_up  out  1  one-cycle pulse at round expiry.
REQ-015 state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 FSM: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN -final tick-> DONE; DONE -start-> RUN.
REQ-017 start in any state loads seconds=ROUND_SEC, clears prescaler, clears latched score, enters RUN next cycle.
REQ-018 start and pause in the same cycle: start wins, pause ignored.
REQ-019 pause in IDLE or DONE ignored.
REQ-020 Prescaler counts 0..CLK_HZ-1 in RUN only; holds value in PAUSE; wraps to 0 with one-cycle tick at CLK_HZ-1.
REQ-021 Seconds held as two BCD digits; tick decrements with borrow (ones 0 -> 9, tens-1); never below 00.
REQ-022 Tick when seconds=01: seconds -> 00, state -> DONE, time_up high for exactly the following cycle.
REQ-023 digit outputs registered; reflect new seconds value one cycle after tick.
REQ-024 IDLE displays ROUND_SEC; RUN/PAUSE display current seconds.
REQ-025 DONE displays latched score; before any score_valid in DONE, displays 00.
REQ-026 score_valid accepted only in DONE; score >99 saturates to 99; binary-to-BCD via tens/ones split, result registered.
REQ-027 Leading-zero blanking in IDLE/RUN/PAUSE: one_en=0 when tens=0; two_en=1. DONE: one_en=two_en=1.
REQ-028 In PAUSE, display steady (no blink) regardless of seconds.

Reset
REQ-029 rst_n low: state=IDLE, prescaler=0, seconds=ROUND_SEC, latched score=0, time_up=0, blink phase=0.
REQ-030 Outputs during/after reset: digit_one/digit_two=ROUND_SEC BCD, enables per REQ-027, state=00.
REQ-031 Reset mid-round abandons round without time_up pulse.

Configuration
REQ-032 Macro SSD_ROUND_BLINK_EN defined: in RUN with 1<=seconds<=BLINK_SEC, both enables forced 0 while prescaler >= CLK_HZ/2, else per REQ-027.
REQ-033 Macro undefined: no blink logic; enables always per REQ-027.

Verification (CLK_HZ=10, ROUND_SEC=12, BLINK_SEC=5)
REQ-034 Reset release -> digits 1,2, one_en=1, two_en=1, state=00; start -> state=01, 10 cycles later digits 1,1.
REQ-035 Run to expiry -> 120 cycles after start: state=11, digits 0,0, single time_up pulse; seconds 09 shows one_en=0.
REQ-036 pause at seconds=07 for 50 cycles, pause again -> digits hold 0,7; remaining expiry delayed exactly 50 cycles.
REQ-037 DONE, score_valid with score=123 -> digits 9,9; then score=47 -> 4,7; start -> digits 1,2, state=01.
REQ-038 start and pause same cycle in RUN -> restart to 12, state=01; rst_n low mid-round -> state=00, no time_up.
REQ-039 SSD_ROUND_BLINK_EN defined, seconds=03 -> enables 1 for prescaler 0..4, 0 for 5..9; undefined -> enables steady.
